// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC address handshake, single outstanding memory read, FWFT buffer.
// Optional memory-wait abort enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr_in,
   input  logic        addr_valid,
   output logic        addr_ready,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [15:0] instr_addr,
   input  logic        flush,
   output logic        fetch_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

   state_t        r_state;
   logic [15:0]   r_mem_addr;
   logic [15:0]   r_data [FIFO_DEPTH];
   logic [15:0]   r_tag  [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;

   logic w_full;
   logic w_xfer;
   logic w_push;
   logic w_pop;
   logic w_tmo;

   assign w_full      = (r_cnt == DEPTH_C);
   assign addr_ready  = ~reset & (r_state == IDLE) & ~w_full & ~flush;
   assign w_xfer      = addr_valid & addr_ready;
   assign w_push      = (r_state == BUSY) & mem_ack & ~flush;
   assign instr_valid = (r_cnt != '0);
   assign w_pop       = instr_valid & instr_ready & ~flush;
   assign mem_req     = (r_state != IDLE);
   assign mem_addr    = r_mem_addr;
   assign instr       = instr_valid ? r_data[r_rp] : 16'h0000;
   assign instr_addr  = instr_valid ? r_tag[r_rp] : 16'h0000;

`ifdef FETCH_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_tmo;
   logic          r_fetch_err;

   // BUSY with flush restarts the wait in DROP, so it never times out here
   assign w_tmo = (r_state != IDLE) & ~mem_ack & (r_tmo == TMAX)
                & ~((r_state == BUSY) & flush);
   assign fetch_err = r_fetch_err;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tmo       <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_fetch_err <= w_tmo;
         if (w_tmo || r_state == IDLE || mem_ack ||
             (r_state == BUSY && flush))
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + 1'b1;
      end
   end
`else
   assign w_tmo     = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_mem_addr <= 16'h0000;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_mem_addr <= addr_in;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               // ack together with flush completes the read, data unused
               if (mem_ack)    r_state <= IDLE;
               else if (flush) r_state <= DROP;
               else if (w_tmo) r_state <= IDLE;
            end
            DROP: begin
               if (mem_ack || w_tmo) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // storage needs no reset; visibility is gated by the count
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_data[r_wp] <= mem_rdata;
         r_tag[r_wp]  <= r_mem_addr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetch, fill, flush, push/pop, timeout, reset.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr_in = '0;
   logic        addr_valid = 1'b0;
   logic        addr_ready;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr;
   logic [15:0] instr_addr;
   logic        flush = 1'b0;
   logic        fetch_err;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] sb [$];

   instr_fetch_unit #(.FIFO_DEPTH(4), .TIMEOUT_CYC(15)) dut (
      .clock(clock), .reset(reset),
      .addr_in(addr_in), .addr_valid(addr_valid), .addr_ready(addr_ready),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_addr(instr_addr),
      .flush(flush), .fetch_err(fetch_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // stimulus only: one complete fetch, expected entry queued at ack
   task automatic fetch(input logic [15:0] a, input logic [15:0] d, input int lat);
      int n = 0;
      addr_in = a;
      addr_valid = 1'b1;
      while (!addr_ready && n < 20) begin
         tick();
         n++;
      end
      if (!addr_ready) begin
         n_total++;
         $display("FAIL fetch_handshake addr=%h: addr_ready never rose", a);
      end
      tick();
      addr_valid = 1'b0;
      repeat (lat - 1) tick();
      mem_rdata = d;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      sb.push_back({a, d});
   endtask

   task automatic test_reset();
      logic [31:0] obs;
      repeat (2) tick();
      obs = {addr_ready, mem_req, instr_valid, fetch_err, mem_addr, 12'h000};
      n_total++;
      if (obs !== 32'h0) $display("FAIL reset_state got %h want %h", obs, 32'h0);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_total++;
      if (addr_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", addr_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_single_fetch();
      logic [31:0] exp;
      addr_in = 16'h0001;
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      n_total++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b0})
         $display("FAIL single_req1 got %b/%h/%b want 1/0001/0", mem_req, mem_addr, instr_valid);
      else n_pass++;
      tick();
      n_total++;
      if (mem_req !== 1'b1) $display("FAIL single_req2 got %b want 1", mem_req);
      else n_pass++;
      mem_rdata = 16'hA5A5;
      mem_ack = 1'b1;
      sb.push_back({16'h0001, 16'hA5A5});
      tick();
      mem_ack = 1'b0;
      n_total++;
      if ({mem_req, instr_valid} !== 2'b01)
         $display("FAIL single_after_ack got req=%b valid=%b want 0 1", mem_req, instr_valid);
      else n_pass++;
      exp = sb.pop_front();
      n_total++;
      if ({instr_addr, instr} !== exp) $display("FAIL single_data got %h want %h", {instr_addr, instr}, exp);
      else n_pass++;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_total++;
      if (instr_valid !== 1'b0) $display("FAIL single_popped got %b want 0", instr_valid);
      else n_pass++;
   endtask

   task automatic test_fill();
      logic [31:0] exp;
      int n;
      for (int i = 0; i < 4; i++) fetch(16'h0010 + 16'(i), 16'hC000 + 16'(i), 1 + i % 3);
      n_total++;
      if (addr_ready !== 1'b0) $display("FAIL fill_full_ready got %b want 0", addr_ready);
      else n_pass++;
      instr_ready = 1'b1;
      exp = sb.pop_front();
      n_total++;
      if ({instr_addr, instr} !== exp) $display("FAIL fill_head got %h want %h", {instr_addr, instr}, exp);
      else n_pass++;
      tick();
      instr_ready = 1'b0;
      n_total++;
      if (addr_ready !== 1'b1) $display("FAIL fill_ready_after_pop got %b want 1", addr_ready);
      else n_pass++;
      n = 0;
      instr_ready = 1'b1;
      while (sb.size() > 0 && n < 20) begin
         if (instr_valid) begin
            exp = sb.pop_front();
            n_total++;
            if ({instr_addr, instr} !== exp) $display("FAIL fill_order got %h want %h", {instr_addr, instr}, exp);
            else n_pass++;
         end
         tick();
         n++;
      end
      instr_ready = 1'b0;
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL fill_drain_timeout left %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_flush();
      fetch(16'h0020, 16'h1111, 1);
      fetch(16'h0021, 16'h2222, 2);
      addr_in = 16'h0008;
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      n_total++;
      if ({instr_valid, mem_req, addr_ready} !== 3'b010)
         $display("FAIL flush_drop got v/req/rdy=%b%b%b want 010", instr_valid, mem_req, addr_ready);
      else n_pass++;
      tick();
      mem_rdata = 16'h1234;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if ({instr_valid, mem_req, addr_ready} !== 3'b001)
         $display("FAIL flush_after_ack got v/req/rdy=%b%b%b want 001", instr_valid, mem_req, addr_ready);
      else n_pass++;
   endtask

   task automatic test_push_pop();
      logic [31:0] exp;
      fetch(16'h0030, 16'h3030, 1);
      addr_in = 16'h0031;
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      exp = sb.pop_front();
      n_total++;
      if ({instr_addr, instr} !== exp) $display("FAIL pp_old_head got %h want %h", {instr_addr, instr}, exp);
      else n_pass++;
      instr_ready = 1'b1;
      mem_rdata = 16'h3131;
      mem_ack = 1'b1;
      sb.push_back({16'h0031, 16'h3131});
      tick();
      instr_ready = 1'b0;
      mem_ack = 1'b0;
      exp = sb.pop_front();
      n_total++;
      if ({instr_valid, instr_addr, instr} !== {1'b1, exp})
         $display("FAIL pp_new_head got %b/%h want 1/%h", instr_valid, {instr_addr, instr}, exp);
      else n_pass++;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      n_total++;
      if (instr_valid !== 1'b0) $display("FAIL pp_count_one got valid=%b want 0", instr_valid);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int n = 0;
      fetch(16'h0040, 16'h4040, 1);
      addr_in = 16'h0041;
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      while (mem_req && n < 40) begin
         n_total++;
         if (fetch_err !== 1'b0) $display("FAIL tmo_err_early got %b want 0 at %0d", fetch_err, n);
         else n_pass++;
         tick();
         n++;
      end
`ifdef FETCH_TIMEOUT_EN
      n_total++;
      if (n !== 15) $display("FAIL tmo_req_cycles got %0d want 15", n);
      else n_pass++;
      n_total++;
      if (fetch_err !== 1'b1) $display("FAIL tmo_err_pulse got %b want 1", fetch_err);
      else n_pass++;
      tick();
      n_total++;
      if (fetch_err !== 1'b0) $display("FAIL tmo_err_clear got %b want 0", fetch_err);
      else n_pass++;
`else
      n_total++;
      if (mem_req !== 1'b1) $display("FAIL tmo_req_hold got %b want 1 after %0d", mem_req, n);
      else n_pass++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      sb.delete();
      n_total++;
      if ({mem_req, instr_valid, addr_ready} !== 3'b001)
         $display("FAIL tmo_recover got req/v/rdy=%b%b%b want 001", mem_req, instr_valid, addr_ready);
      else n_pass++;
`endif
`ifdef FETCH_TIMEOUT_EN
      n_total++;
      if ({instr_valid, instr_addr, instr} !== {1'b1, sb[0]})
         $display("FAIL tmo_fifo got %b/%h want 1/%h", instr_valid, {instr_addr, instr}, sb[0]);
      else n_pass++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
`endif
   endtask

   task automatic test_reset_mid();
      logic [63:0] obs;
      fetch(16'h0050, 16'h5050, 1);
      addr_in = 16'h0051;
      addr_valid = 1'b1;
      tick();
      addr_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      obs = {mem_req, addr_ready, instr_valid, fetch_err, 12'h000, mem_addr, instr, instr_addr};
      n_total++;
      if (obs !== 64'h0) $display("FAIL rst_mid_outputs got %h want 0", obs);
      else n_pass++;
      tick();
      reset = 1'b0;
      mem_rdata = 16'hDEAD;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      n_total++;
      if ({mem_req, instr_valid} !== 2'b00)
         $display("FAIL rst_late_ack got req=%b valid=%b want 00", mem_req, instr_valid);
      else n_pass++;
      tick();
      n_total++;
      if ({instr_valid, addr_ready} !== 2'b01)
         $display("FAIL rst_idle got valid=%b rdy=%b want 0 1", instr_valid, addr_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_fill();
      test_flush();
      test_push_pop();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
